// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one 1-bit cell sequenced LSB-first; WIDTH cycles start->done, then one IDLE cycle before the next start.
// start is ignored while busy. Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             sub_w;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // One-bit cell: two half adders plus an OR for the carry.
  logic ha1_s, ha1_c, ha2_s, ha2_c, c_next;
  assign ha1_s  = a_sr_q[0] ^ b_sr_q[0];
  assign ha1_c  = a_sr_q[0] & b_sr_q[0];
  assign ha2_s  = ha1_s ^ c_q;
  assign ha2_c  = ha1_s & c_q;
  assign c_next = ha1_c | ha2_c;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = sub_w ? ~b : b;
          c_d     = sub_w;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        res_d  = {ha2_s, res_q[WIDTH-1:1]};
        c_d    = c_next;
        cnt_d  = cnt_q + 1'b1;
        // sum/cout update only here so partial results are never visible.
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed vector table plus hand sequences for reset, busy protection, held start and abort.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       sub;
  logic       busy, done, cout;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int n;
    logic [7:0] prev_sum;
    prev_sum = sum;
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 4) chk("no_partial_sum", sum, prev_sum);
      if (done) begin n = i; break; end
    end
    chk("latency", n, 8);
    chk("sum", sum, v.s);
    chk("cout", cout, v.c);
    chk("busy_at_done", busy, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int dcnt, rise1, rise2, nrise;
    logic prev_busy;
    logic [7:0] got_sum;

    vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1});
    vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h55, 8'h55, 1'b1, 8'h00, 1'b1});
`endif

    // Reset with start held high: nothing may start.
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
    end
    start = 1'b0; rst = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Operand and start changes while busy are ignored.
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0; got_sum = 8'h00;
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      tick();
      if (i == 3) start = 1'b0;
      if (done) begin dcnt++; got_sum = sum; end
    end
    chk("busyprot_done_count", dcnt, 1);
    chk("busyprot_sum", got_sum, 8'h03);
    chk("busyprot_idle", busy, 0);

    // start held high: accepted every WIDTH+2 edges.
    a = 8'h01; b = 8'h01; start = 1'b1;
    prev_busy = busy;
    rise1 = 0; rise2 = 0; nrise = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (busy && !prev_busy) begin
        nrise++;
        if (nrise == 1) rise1 = i;
        if (nrise == 2) rise2 = i;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("held_first_accept", rise1, 1);
    chk("held_second_accept", rise2, 11);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("held_drain", busy, 0);
    chk("held_sum", sum, 8'h02);

    // Abort mid-operation.
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", cout, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit adder cell (two half adders plus an OR for carry) over WIDTH-bit operands, LSB first, one bit per clock. It sits between a requester and the shared one-bit datapath. It captures operands on a start handshake, runs a counter-driven FSM with a carry flip-flop, and presents a registered WIDTH-bit result with carry-out and a one-cycle done pulse.

## Interface
- WIDTH, default 8, operand/result width in bits; legal range 2..32.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- sub  input  1  subtract select; captured on accepted start. Present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until next completion.
- cout  output  1  registered carry-out of the MSB; held with sum.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE with start=1: load a and b into shift registers. Clear carry FF to 0. Clear bit counter to 0. Go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - Compute bit = a_sr[0] ^ b_sr[0] ^ c.
  - Compute c_next = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0])), built from two half-adder stages.
  - Shift a_sr and b_sr right by 1.
  - Shift bit into the MSB of the internal result register, which shifts right.
  - Increment the counter.
- RUN, edge where counter = WIDTH-1: process the last bit. Load sum from the completed internal register and cout from c_next. Go to DONE.
- DONE: done=1 for this cycle. Unconditionally go to IDLE on the next edge.
- start is ignored in RUN and DONE. Operand, sub, and start changes while busy have no effect.
- sum and cout never show partial results. They change only on the completing edge or on reset.
- Counter width is clog2(WIDTH)+1 bits. It never wraps during an operation.
- Arithmetic is modulo 2^WIDTH. The carry out of the MSB goes only to cout.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Counter, carry FF and shift registers are all 0.
- rst has priority over start on the same edge.
- rst during RUN or DONE aborts the operation. No done pulse is issued. Outputs return to reset values on that edge.
- Start accepted at edge k:
  - busy=1 from edge k.
  - Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH.
  - sum, cout and done=1 are valid after edge k+WIDTH.
  - done=0 and busy=0 after edge k+WIDTH+1.
- Latency: WIDTH cycles from the start edge to done.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepted start is edge k+WIDTH+2, including when start is held high continuously.
- done is exactly one cycle wide and never asserted outside DONE.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub port exists and is captured on accepted start.
  - When sub=1, b_sr is loaded with ~b and the carry FF is initialised to 1, giving a - b two's complement.
  - cout=1 means no borrow.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port.
  - The carry FF always initialises to 0. Add only.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0 throughout. No operation starts.
- Basic add: a=0x35, b=0x4A, start pulsed at edge k -> done=1 only after edge k+8, sum=0x7F, cout=0. busy high from edge k to edge k+9.
- Overflow: a=0xFF, b=0x01 -> sum=0x00, cout=1.
- Busy protection and back-to-back:
  - Start at k with a=0x01, b=0x02, then change a/b and pulse start at k+3 -> result still 0x03 and exactly one done.
  - start held high continuously -> accepted starts at k and k+10.
- Abort: start a=0xAA, b=0x55, assert rst at edge k+4 -> busy=0 and sum=0x00 after k+4. No done in the following 10 cycles.
- SERIAL_ADDER_SUB_EN only:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.
